// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control,
// a running XOR accumulator and registered zero/parity flags on each result.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_ACC  = 3'd7;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic zero_f(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_result_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             parity_r;
    logic [WIDTH-1:0] acc_r;

    logic             accept_s;
    logic             s1_advance_s;
    logic             s2_drain_s;
    logic             in_ready_s;
    logic             acc_op_s;
    logic [WIDTH-1:0] acc_eff_s;
    logic [WIDTH-1:0] op_result_s;
    logic [WIDTH-1:0] acc_next_s;

    // S1 may move on whenever S2 is empty or is being drained this cycle, so
    // in_ready sees out_ready combinationally and the pipe runs bubble-free.
    assign s1_advance_s = s1_valid_r && (!s2_valid_r || out_ready);
    assign in_ready_s   = !s1_valid_r || s1_advance_s;
    assign accept_s     = in_valid && in_ready_s;
    assign s2_drain_s   = s2_valid_r && out_ready;
    assign acc_op_s     = accept_s && (op == OP_ACC);

    // Operation decode; a clear in the same cycle makes ACC see a zero accumulator.
    always_comb begin
        acc_eff_s   = {WIDTH{1'b0}};
        op_result_s = {WIDTH{1'b0}};
        if (acc_clr) begin
            acc_eff_s = {WIDTH{1'b0}};
        end else begin
            acc_eff_s = acc_r;
        end
        case (op)
            OP_AND:  op_result_s = a & b;
            OP_OR:   op_result_s = a | b;
            OP_NAND: op_result_s = ~(a & b);
            OP_NOR:  op_result_s = ~(a | b);
            OP_XOR:  op_result_s = a ^ b;
            OP_XNOR: op_result_s = ~(a ^ b);
            OP_NOT:  op_result_s = ~a;
            OP_ACC:  op_result_s = acc_eff_s ^ a;
            default: op_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Accumulator next value: clear-with-ACC loads a, clear alone zeroes.
    always_comb begin
        acc_next_s = acc_r;
        if (acc_clr && acc_op_s) begin
            acc_next_s = a;
        end else if (acc_clr) begin
            acc_next_s = {WIDTH{1'b0}};
        end else if (acc_op_s) begin
            acc_next_s = acc_r ^ a;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Accumulator register, updated at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
        end else begin
            acc_r <= acc_next_s;
        end
    end

    // Stage 1: captures the computed result on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_result_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_result_r <= op_result_s;
        end else if (s1_advance_s) begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Stage 2: output register with flags; holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b1;
            parity_r   <= 1'b0;
        end else if (s1_advance_s) begin
            s2_valid_r <= 1'b1;
            result_r   <= s1_result_r;
            zero_r     <= zero_f(s1_result_r);
            parity_r   <= parity_f(s1_result_r);
        end else if (s2_drain_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign parity    = parity_r;
    assign acc       = acc_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vectors on a WIDTH=8 instance and a
// randomized scoreboard run on a WIDTH=13 instance, both checked every cycle.
module tb_logic_unit_pipe;

    typedef struct {
        logic [15:0] res;
        logic        zero;
        logic        par;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        clr;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        logic        zero;
        logic        par;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        iv[2];
    logic        ordy[2];
    logic        clr_v[2];
    logic [2:0]  op_v[2];
    logic [15:0] a_v[2];
    logic [15:0] b_v[2];

    logic        ir0, ir1, ov0, ov1, zr0, zr1, pr0, pr1;
    logic [7:0]  res8, acc8;
    logic [12:0] res13, acc13;
    logic        ir_w[2], ov_w[2], zr_w[2], pr_w[2];
    logic [15:0] res_w[2], acc_w[2];

    assign ir_w[0] = ir0;  assign ir_w[1] = ir1;
    assign ov_w[0] = ov0;  assign ov_w[1] = ov1;
    assign zr_w[0] = zr0;  assign zr_w[1] = zr1;
    assign pr_w[0] = pr0;  assign pr_w[1] = pr1;
    assign res_w[0] = {8'h00, res8};
    assign res_w[1] = {3'b000, res13};
    assign acc_w[0] = {8'h00, acc8};
    assign acc_w[1] = {3'b000, acc13};

    logic_unit_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .op(op_v[0]), .acc_clr(clr_v[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .result(res8), .zero(zr0),
        .parity(pr0), .acc(acc8)
    );

    logic_unit_pipe #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_v[1][12:0]), .b(b_v[1][12:0]), .op(op_v[1]), .acc_clr(clr_v[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .result(res13), .zero(zr1),
        .parity(pr1), .acc(acc13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] macc[2];
    logic        last_acc[2];
    logic        lat_chk;
    logic        tbl_v;
    logic [7:0]  tbl_res;
    logic        tbl_zero, tbl_par;

    function automatic logic [15:0] mask_of(input int d);
        return (d == 0) ? 16'h00FF : 16'h1FFF;
    endfunction

    // Reference semantics of the eight operations.
    function automatic logic [15:0] mop(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [15:0] av,
                                        input logic [15:0] m);
        logic [15:0] r;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = ~(x & y);
            3'd3: r = ~(x | y);
            3'd4: r = x ^ y;
            3'd5: r = ~(x ^ y);
            3'd6: r = ~x;
            default: r = av ^ x;
        endcase
        return r & m;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check handshake and outputs of both DUTs, update the model, step.
    task automatic cycle();
        exp_t        e;
        int          sz;
        logic        af, of;
        logic [15:0] m, av, aa;
        #1;
        for (int d = 0; d < 2; d++) begin
            m  = mask_of(d);
            sz = (d == 0) ? q0.size() : q1.size();
            chk((d == 0) ? "in_ready8" : "in_ready13", {15'h0, ir_w[d]},
                {15'h0, (sz < 2) || ordy[d]});
            af = iv[d] && ir_w[d];
            of = ov_w[d] && ordy[d];
            last_acc[d] = af;
            if (of) begin
                if (sz == 0) begin
                    chk((d == 0) ? "spurious8" : "spurious13", {15'h0, ov_w[d]}, 16'h0000);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk((d == 0) ? "result8" : "result13", res_w[d], e.res);
                    chk((d == 0) ? "zero8" : "zero13", {15'h0, zr_w[d]}, {15'h0, e.zero});
                    chk((d == 0) ? "parity8" : "parity13", {15'h0, pr_w[d]}, {15'h0, e.par});
                    if (d == 0 && lat_chk) chk("latency8", 16'(cyc - e.cyc), 16'd2);
                end
            end
            aa = a_v[d] & m;
            av = clr_v[d] ? 16'h0000 : macc[d];
            if (af) begin
                if (d == 0 && tbl_v) begin
                    e.res = {8'h00, tbl_res}; e.zero = tbl_zero; e.par = tbl_par;
                end else begin
                    e.res  = mop(op_v[d], aa, b_v[d] & m, av, m);
                    e.zero = (e.res == 16'h0000);
                    e.par  = ^e.res;
                end
                e.cyc = cyc;
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (af && op_v[d] == 3'd7) macc[d] = av ^ aa;
            else if (clr_v[d])         macc[d] = 16'h0000;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("acc8", acc_w[0], macc[0]);
        chk("acc13", acc_w[1], macc[1]);
    endtask

    // Offer one transaction on the 8-bit DUT for a single cycle.
    task automatic send8(input logic clr, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y);
        iv[0] = 1'b1; clr_v[0] = clr; op_v[0] = o; a_v[0] = {8'h00, x}; b_v[0] = {8'h00, y};
        cycle();
        iv[0] = 1'b0; clr_v[0] = 1'b0;
    endtask

    task automatic send_exp(input vec_t v);
        tbl_v = 1'b1; tbl_res = v.res; tbl_zero = v.zero; tbl_par = v.par;
        send8(v.clr, v.op, v.a, v.b);
        tbl_v = 1'b0;
        chk("accepted", {15'h0, last_acc[0]}, 16'h0001);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    vec_t        vecs[10];
    vec_t        chain[4];
    logic [2:0]  bp_op[4];
    int          k;

    initial begin
        vecs[0] = '{1'b0, 3'd0, 8'hCA, 8'h5C, 8'h48, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 3'd1, 8'hCA, 8'h5C, 8'hDE, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'd2, 8'hCA, 8'h5C, 8'hB7, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'd3, 8'hCA, 8'h5C, 8'h21, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 3'd4, 8'hCA, 8'h5C, 8'h96, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 3'd5, 8'hCA, 8'h5C, 8'h69, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 3'd6, 8'hCA, 8'h5C, 8'h35, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 3'd7, 8'hCA, 8'h5C, 8'hCA, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 3'd0, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 3'd4, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};
        chain[0] = '{1'b0, 3'd7, 8'h11, 8'h00, 8'h11, 1'b0, 1'b0};
        chain[1] = '{1'b0, 3'd7, 8'h22, 8'h00, 8'h33, 1'b0, 1'b0};
        chain[2] = '{1'b0, 3'd7, 8'h11, 8'h00, 8'h22, 1'b0, 1'b0};
        chain[3] = '{1'b1, 3'd7, 8'h05, 8'hFF, 8'h05, 1'b0, 1'b0};
        bp_op[0] = 3'd0; bp_op[1] = 3'd1; bp_op[2] = 3'd4; bp_op[3] = 3'd6;

        rst_n = 1'b0; lat_chk = 1'b1; tbl_v = 1'b0;
        tbl_res = 8'h00; tbl_zero = 1'b0; tbl_par = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; clr_v[d] = 1'b0; op_v[d] = 3'd0;
            a_v[d] = 16'h0000; b_v[d] = 16'h0000; macc[d] = 16'h0000; last_acc[d] = 1'b0;
        end
        #12;
        chk("rst_out_valid", {15'h0, ov0}, 16'h0000);
        chk("rst_result", res_w[0], 16'h0000);
        chk("rst_zero", {15'h0, zr0}, 16'h0001);
        chk("rst_parity", {15'h0, pr0}, 16'h0000);
        chk("rst_acc", acc_w[0], 16'h0000);
        chk("rst_in_ready", {15'h0, ir0}, 16'h0001);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All eight ops plus flag corners, streamed back to back.
        for (int i = 0; i < 10; i++) send_exp(vecs[i]);
        idle(4);

        // Accumulator chain, then clear-with-ACC, then clear alone.
        clr_v[0] = 1'b1; cycle(); clr_v[0] = 1'b0;
        chk("acc_cleared", acc_w[0], 16'h0000);
        for (int i = 0; i < 3; i++) send_exp(chain[i]);
        idle(3);
        chk("acc_chain_end", acc_w[0], 16'h0022);
        send_exp(chain[3]);
        idle(3);
        chk("acc_clr_acc", acc_w[0], 16'h0005);
        clr_v[0] = 1'b1; cycle(); clr_v[0] = 1'b0;
        chk("acc_clr_alone", acc_w[0], 16'h0000);

        // Backpressure: four offered, only two fit while out_ready is low.
        lat_chk = 1'b0; ordy[0] = 1'b0; k = 0;
        for (int t = 0; t < 6; t++) begin
            iv[0] = (k < 4); op_v[0] = bp_op[k % 4]; a_v[0] = 16'h00CA; b_v[0] = 16'h005C;
            cycle();
            if (last_acc[0]) k++;
            if (t >= 1) chk("bp_stable", res_w[0], 16'h0048);
        end
        chk("bp_accepted", 16'(k), 16'd2);
        chk("bp_in_ready", {15'h0, ir0}, 16'h0000);
        chk("bp_out_valid", {15'h0, ov0}, 16'h0001);
        ordy[0] = 1'b1;
        for (int t = 0; t < 40 && (k < 4 || q0.size() != 0); t++) begin
            iv[0] = (k < 4); op_v[0] = bp_op[k % 4];
            cycle();
            if (last_acc[0]) k++;
        end
        iv[0] = 1'b0;
        chk("bp_all_accepted", 16'(k), 16'd4);
        chk("bp_drained", 16'(q0.size()), 16'd0);
        idle(3);

        // Reset while two transactions are in flight and acc = 0x7E.
        lat_chk = 1'b1;
        send_exp('{1'b1, 3'd7, 8'h7E, 8'h00, 8'h7E, 1'b0, 1'b0});
        idle(3);
        chk("acc_7e", acc_w[0], 16'h007E);
        ordy[0] = 1'b0;
        send8(1'b0, 3'd1, 8'h12, 8'h34);
        send8(1'b0, 3'd4, 8'h56, 8'h78);
        chk("inflight_two", 16'(q0.size()), 16'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {15'h0, ov0}, 16'h0000);
        chk("mid_rst_acc", acc_w[0], 16'h0000);
        chk("mid_rst_result", res_w[0], 16'h0000);
        chk("mid_rst_zero", {15'h0, zr0}, 16'h0001);
        q0.delete(); q1.delete(); macc[0] = 16'h0000; macc[1] = 16'h0000;
        #2 rst_n = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {15'h0, ir0}, 16'h0001);
        for (int t = 0; t < 5; t++) begin
            cycle();
            chk("no_stale_out", {15'h0, ov0}, 16'h0000);
        end

        // Random traffic on the 13-bit instance against the model.
        for (int n = 0; n < 3000; n++) begin
            if (!iv[1] || last_acc[1]) begin
                iv[1]   = ($urandom_range(0, 3) != 0);
                op_v[1] = 3'($urandom_range(0, 7));
                a_v[1]  = 16'($urandom_range(0, 16'h1FFF));
                b_v[1]  = 16'($urandom_range(0, 16'h1FFF));
            end
            ordy[1]  = ($urandom_range(0, 3) != 0);
            clr_v[1] = ($urandom_range(0, 15) == 0);
            cycle();
        end
        iv[1] = 1'b0; clr_v[1] = 1'b0; ordy[1] = 1'b1;
        idle(6);
        chk("rand_drained", 16'(q1.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
